// File: rtl/skipdecode.sv
// ---------------------------------------------------------------------------
// skipdecode
//
// Recovers the skip pattern of a clock-gating stream. Each clock cycle is one
// slot. GATE says whether that slot's gated pulse was passed (1) or skipped
// (0). B0 marks slot 0 of each LEN-slot frame. The block aligns to B0 and
// rebuilds the per-frame skip mask. At the end of every complete frame it
// reports the mask and the number of delivered pulses. It also tracks whether
// the pattern is stable from frame to frame.
//
// Ports:
//   iCLK     in   1    single clock, everything happens on the rising edge
//   nRST     in   1    asynchronous active-low reset
//   GATE     in   1    per-slot delivery flag (1 = pulse passed, 0 = skipped)
//   B0       in   1    frame marker, high during slot 0
//   MASKOUT  out  LEN  skip mask of the last complete frame (bit i = slot i skipped)
//   CNT      out  CW   delivered pulses in the last complete frame
//   VALID    out  1    one-cycle strobe, MASKOUT/CNT were just updated
//   LOCK     out  1    level, two or more consecutive identical frames seen
//   ERR      out  1    one-cycle strobe, frame alignment violation
// ---------------------------------------------------------------------------
module skipdecode #(
    parameter int LEN = 16,
    parameter int CW  = $clog2(LEN + 1)
) (
    input  logic           iCLK,
    input  logic           nRST,
    input  logic           GATE,
    input  logic           B0,
    output logic [LEN-1:0] MASKOUT,
    output logic [CW-1:0]  CNT,
    output logic           VALID,
    output logic           LOCK,
    output logic           ERR
);

    localparam int             IW   = $clog2(LEN);
    localparam logic [IW-1:0]  LAST = IW'(LEN - 1);

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [IW-1:0]   r_idx;

    // Slots 0..LEN-2 are buffered. Slot LEN-1 goes straight from the input
    // into the completed frame on the edge that samples it.
    logic [LEN-2:0]  r_frame;
    logic [LEN-1:0]  r_prev;
    logic [1:0]      r_match;

    logic            w_start;
    logic            w_capture;
    logic            w_done;
    logic            w_err;
    logic            w_toHunt;
    logic [LEN-1:0]  w_full;
    logic [CW-1:0]   w_ones;

    // State register.
    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state. A missing B0 at the expected slot 0 means alignment is
    // gone and the block must hunt for a marker. A B0 that comes early only
    // resyncs and stays in TRACK.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            HUNT:    if (B0) w_stateNext = TRACK;
            TRACK:   if (!B0 && (r_idx == '0)) w_stateNext = HUNT;
            default: w_stateNext = HUNT;
        endcase
    end

    // Per-sample control decode.
    //   w_start   : this sample is slot 0 of a new frame
    //   w_capture : this sample is a later slot of the current frame
    //   w_done    : this sample is slot LEN-1, so the frame completes
    // An early B0 sets both w_err and w_start, which is the immediate resync.
    // Because of that, an early B0 at idx LEN-1 never completes a frame.
    always_comb begin
        w_start   = 1'b0;
        w_capture = 1'b0;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_toHunt  = 1'b0;
        case (r_state)
            HUNT: begin
                w_start = B0;
            end
            TRACK: begin
                if (B0 && (r_idx != '0)) begin
                    w_err   = 1'b1;
                    w_start = 1'b1;
                end else if (!B0 && (r_idx == '0)) begin
                    w_err    = 1'b1;
                    w_toHunt = 1'b1;
                end else if (r_idx == '0) begin
                    w_start = 1'b1;
                end else begin
                    w_capture = 1'b1;
                    w_done    = (r_idx == LAST);
                end
            end
            default: begin
                w_toHunt = 1'b1;
            end
        endcase
    end

    // The completed frame takes its final bit from the live sample.
    always_comb begin
        w_full = {~GATE, r_frame};
    end

    // Skipped-slot count. CNT is LEN minus this value.
    always_comb begin
        w_ones = '0;
        for (int i = 0; i < LEN; i++) begin
            w_ones = w_ones + CW'(w_full[i]);
        end
    end

    // Slot index and frame buffer.
    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            r_idx   <= '0;
            r_frame <= '0;
        end else begin
            if (w_start) begin
                r_idx      <= IW'(1);
                r_frame    <= '0;
                r_frame[0] <= ~GATE;
            end else if (w_capture) begin
                if (w_done) begin
                    r_idx <= '0;
                end else begin
                    r_idx          <= r_idx + IW'(1);
                    r_frame[r_idx] <= ~GATE;
                end
            end else if (w_toHunt) begin
                r_idx <= '0;
            end
        end
    end

    // Result registers, strobes and frame-to-frame match tracking.
    // r_match is nonzero only if the last completed frame had no ERR after
    // it, so the "previous frame was clean" condition reads r_match != 0.
    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            MASKOUT <= '0;
            CNT     <= '0;
            VALID   <= 1'b0;
            ERR     <= 1'b0;
            r_prev  <= '0;
            r_match <= 2'd0;
        end else begin
            VALID <= w_done;
            ERR   <= w_err;
            if (w_done) begin
                MASKOUT <= w_full;
                CNT     <= CW'(LEN) - w_ones;
                r_prev  <= w_full;
                if ((w_full == r_prev) && (r_match != 2'd0)) begin
                    r_match <= (r_match == 2'd2) ? 2'd2 : r_match + 2'd1;
                end else begin
                    r_match <= 2'd1;
                end
            end else if (w_err) begin
                r_match <= 2'd0;
            end
        end
    end

    assign LOCK = (r_match == 2'd2);

endmodule

// File: tb/tb_skipdecode.sv
// ---------------------------------------------------------------------------
// tb_skipdecode
//
// Directed testbench for skipdecode with LEN=16. Slot inputs change on the
// falling edge. Outputs are checked 1 ns after the rising edge that sampled
// the slot, so each check sees the result of that slot's edge.
// ---------------------------------------------------------------------------
module tb_skipdecode;

    logic        iCLK;
    logic        nRST;
    logic        GATE;
    logic        B0;
    logic [15:0] MASKOUT;
    logic [4:0]  CNT;
    logic        VALID;
    logic        LOCK;
    logic        ERR;

    int testCount;
    int failCount;

    skipdecode #(
        .LEN(16)
    ) dut (
        .iCLK    (iCLK),
        .nRST    (nRST),
        .GATE    (GATE),
        .B0      (B0),
        .MASKOUT (MASKOUT),
        .CNT     (CNT),
        .VALID   (VALID),
        .LOCK    (LOCK),
        .ERR     (ERR)
    );

    // 10 ns clock.
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one slot on the falling edge and wait until just after the
    // rising edge that samples it.
    task automatic applyStimulus(input logic gate, input logic b0);
        @(negedge iCLK);
        GATE = gate;
        B0   = b0;
        @(posedge iCLK);
        #1;
    endtask

    // Send slots startSlot..15 of a frame with the given skip mask.
    // No strobe may appear before the last slot. VALID with the expected
    // results must appear right after the slot-15 edge.
    task automatic sendFrame(input logic [15:0] mask, input int startSlot,
                             input logic [4:0] expCnt, input logic expLock,
                             input string name);
        int strobes;
        strobes = 0;
        for (int i = startSlot; i < 16; i++) begin
            applyStimulus(~mask[i], (i == 0));
            if (i < 15) strobes += int'(VALID) + int'(ERR);
        end
        checkOutput({name, "_midStrobes"}, strobes, 0);
        checkOutput({name, "_valid"}, VALID, 1);
        checkOutput({name, "_err"}, ERR, 0);
        checkOutput({name, "_mask"}, MASKOUT, mask);
        checkOutput({name, "_cnt"}, CNT, expCnt);
        checkOutput({name, "_lock"}, LOCK, expLock);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_mask"}, MASKOUT, 0);
        checkOutput({name, "_cnt"}, CNT, 0);
        checkOutput({name, "_valid"}, VALID, 0);
        checkOutput({name, "_lock"}, LOCK, 0);
        checkOutput({name, "_err"}, ERR, 0);
    endtask

    initial begin
        int strobes;
        testCount = 0;
        failCount = 0;
        nRST = 1'b0;
        GATE = 1'b0;
        B0   = 1'b0;

        // Reset state.
        repeat (2) @(negedge iCLK);
        #1;
        checkAllZero("reset");
        nRST = 1'b1;

        // HUNT discards samples without B0.
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            strobes += int'(VALID) + int'(ERR);
        end
        checkOutput("huntIdle_strobes", strobes, 0);

        // Slots 3 and 7 skipped for three frames. LOCK comes at the 2nd VALID.
        sendFrame(16'h0088, 0, 5'd14, 1'b0, "f1");
        sendFrame(16'h0088, 0, 5'd14, 1'b1, "f2");
        sendFrame(16'h0088, 0, 5'd14, 1'b1, "f3");

        // A changed mask drops LOCK without ERR. A repeat relocks it.
        sendFrame(16'h8001, 0, 5'd14, 1'b0, "chg1");
        sendFrame(16'h8001, 0, 5'd14, 1'b1, "chg2");

        // Early B0 at idx 9 while locked: ERR and immediate resync.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(~i[0] | (i != 0), (i == 0));
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("resync_err", ERR, 1);
        checkOutput("resync_lock", LOCK, 0);
        checkOutput("resync_valid", VALID, 0);
        sendFrame(16'h8001, 1, 5'd14, 1'b0, "resyncA");
        sendFrame(16'h8001, 0, 5'd14, 1'b1, "resyncB");

        // Missing B0 at slot 0: ERR, back to HUNT, no VALID until a new B0.
        applyStimulus(1'b1, 1'b0);
        checkOutput("miss_err", ERR, 1);
        checkOutput("miss_lock", LOCK, 0);
        checkOutput("miss_valid", VALID, 0);
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            strobes += int'(VALID) + int'(ERR);
        end
        checkOutput("missHunt_strobes", strobes, 0);

        // Extremes of the mask.
        sendFrame(16'h0000, 0, 5'd16, 1'b0, "allPass");
        sendFrame(16'hFFFF, 0, 5'd0, 1'b0, "allSkip");
        sendFrame(16'h0000, 0, 5'd16, 1'b0, "allPass2");

        // Reset in the middle of a frame, with idx=5 next.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, (i == 0));
        end
        #2;
        nRST = 1'b0;
        #1;
        checkAllZero("midReset");
        @(negedge iCLK);
        @(negedge iCLK);
        B0   = 1'b0;
        nRST = 1'b1;
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            strobes += int'(VALID) + int'(ERR);
        end
        checkOutput("postReset_strobes", strobes, 0);
        sendFrame(16'h0088, 0, 5'd14, 1'b0, "postReset1");
        sendFrame(16'h0088, 0, 5'd14, 1'b1, "postReset2");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
